// File: rtl/xadac_obi_sram.sv
// xadac_obi_sram: OBI scratchpad slave built on a single-port, byte-enabled memory.
// Accepted requests pass through one stage (S1) and then queue in a small
// in-order response FIFO. The FIFO drives the R channel.
// Optional feature: define XADAC_OBI_SRAM_ERR_EN to flag addresses outside
// the memory with rerr. Without it, the upper address bits are ignored.
//
// Handshake semantics:
//   A channel: a transfer happens in a cycle where i_req && o_gnt. o_gnt is
//     combinational from i_req and registered occupancy only.
//   R channel: a transfer happens in a cycle where o_rvalid && i_rready.
//     While o_rvalid is high and i_rready is low, o_rid/o_rdata/o_rerr hold.
module xadac_obi_sram #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 2,
  parameter int Depth     = 1024,
  parameter int RespDepth = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_req,
  output logic                   o_gnt,
  input  logic [AddrWidth-1:0]   i_addr,
  input  logic                   i_we,
  input  logic [DataWidth/8-1:0] i_be,
  input  logic [DataWidth-1:0]   i_wdata,
  input  logic [IdWidth-1:0]     i_aid,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  output logic [IdWidth-1:0]     o_rid,
  output logic [DataWidth-1:0]   o_rdata,
  output logic                   o_rerr
);

  localparam int BeW  = DataWidth / 8;
  localparam int OffW = $clog2(BeW);
  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = $clog2(RespDepth);
  localparam int CntW = PtrW + 1;

  // Storage
  logic [DataWidth-1:0] r_mem [Depth];

  // S1 stage
  logic                 r_s1_valid;
  logic [IdWidth-1:0]   r_s1_id;
  logic [DataWidth-1:0] r_s1_rdata;

  // Response FIFO
  logic [IdWidth-1:0]   r_fifo_id   [RespDepth];
  logic [DataWidth-1:0] r_fifo_data [RespDepth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;

  logic            w_hs;
  logic            w_err;
  logic [IdxW-1:0] w_idx;
  logic [CntW:0]   w_occ;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_addr;

  assign w_idx = i_addr[OffW +: IdxW];
  // The low byte-offset bits are ignored. Without the range check, the upper bits are ignored too.
  assign w_unused_addr = ^i_addr;

`ifdef XADAC_OBI_SRAM_ERR_EN
  logic r_s1_err;
  logic r_fifo_err [RespDepth];
  assign w_err = ({1'b0, i_addr} >= (AddrWidth+1)'(Depth * BeW));
`else
  assign w_err = 1'b0;
`endif

  // Grant only when every accepted transaction has a FIFO slot. A pop in this
  // cycle does not create credit because the count is the registered one.
  assign w_occ = {1'b0, r_count} + {{CntW{1'b0}}, r_s1_valid};
  assign o_gnt = i_req && (w_occ < (CntW+1)'(RespDepth));
  assign w_hs  = i_req && o_gnt;

  assign w_push   = r_s1_valid;
  assign o_rvalid = (r_count != '0);
  assign w_pop    = o_rvalid && i_rready;

  // Byte-enabled write. Out-of-range writes are suppressed when checking is enabled.
  always_ff @(posedge clk) begin
    if (w_hs && i_we && !w_err) begin
      for (int b = 0; b < BeW; b++) begin
        if (i_be[b]) r_mem[w_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Synchronous read into S1. Writes and out-of-range reads respond with zero data.
  always_ff @(posedge clk) begin
    if (w_hs) r_s1_rdata <= (i_we || w_err) ? '0 : r_mem[w_idx];
  end

  // S1 control: valid/id/err captured on handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
`ifdef XADAC_OBI_SRAM_ERR_EN
      r_s1_err   <= 1'b0;
`endif
    end else begin
      r_s1_valid <= w_hs;
      if (w_hs) begin
        r_s1_id  <= i_aid;
`ifdef XADAC_OBI_SRAM_ERR_EN
        r_s1_err <= w_err;
`endif
      end
    end
  end

  // FIFO payload storage, written at the tail on every S1 push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= r_s1_id;
      r_fifo_data[r_wr_ptr] <= r_s1_rdata;
`ifdef XADAC_OBI_SRAM_ERR_EN
      r_fifo_err[r_wr_ptr]  <= r_s1_err;
`endif
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // R outputs come from the FIFO head and read as zero while it is empty
  assign o_rid   = o_rvalid ? r_fifo_id[r_rd_ptr]   : '0;
  assign o_rdata = o_rvalid ? r_fifo_data[r_rd_ptr] : '0;
`ifdef XADAC_OBI_SRAM_ERR_EN
  assign o_rerr  = o_rvalid ? r_fifo_err[r_rd_ptr]  : 1'b0;
`else
  assign o_rerr  = 1'b0;
`endif

endmodule

// File: tb/tb_xadac_obi_sram.sv
// Bench for xadac_obi_sram: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against a transaction-level model.
module tb_xadac_obi_sram;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int DEPTH = 1024;
  localparam int RD = 4;
`ifdef XADAC_OBI_SRAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rstn;
  logic i_req, o_gnt, i_we, o_rvalid, i_rready, o_rerr;
  logic [AW-1:0] i_addr;
  logic [DW/8-1:0] i_be;
  logic [DW-1:0] i_wdata, o_rdata;
  logic [IW-1:0] i_aid, o_rid;

  always #5 clk = ~clk;

  xadac_obi_sram #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .Depth(DEPTH), .RespDepth(RD)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .o_gnt(o_gnt), .i_addr(i_addr), .i_we(i_we), .i_be(i_be),
    .i_wdata(i_wdata), .i_aid(i_aid),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rerr(o_rerr)
  );

  // ---------------- scoreboard / model ----------------
  typedef struct packed {
    logic [IW-1:0] id;
    logic          err;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } resp_t;

  resp_t exp_q[$];
  logic [DW-1:0] mdl [DEPTH];
  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  bit accepted;
  bit tbl_mode = 1'b0;
  logic [DW-1:0] tbl_data;
  logic tbl_err;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level view of the memory: an array of words addressed by byte address / bytes-per-word.
  function automatic resp_t model_accept();
    resp_t r;
    bit oob;
    int idx;
    oob = ERR && (longint'(i_addr) >= longint'(DEPTH * (DW/8)));
    idx = int'((i_addr / (DW/8)) % DEPTH);
    r.id = i_aid;
    r.err = oob;
    r.cyc = cyc;
    r.data = '0;
    if (i_we) begin
      if (!oob)
        for (int b = 0; b < DW/8; b++)
          if (i_be[b]) mdl[idx][b*8 +: 8] = i_wdata[b*8 +: 8];
    end else begin
      r.data = oob ? '0 : mdl[idx];
    end
    return r;
  endfunction

  // One clock cycle. Inputs are already driven. Check outputs, account for the
  // handshakes, then advance to just after the next edge.
  task automatic step();
    resp_t h, r;
    bit exp_rv;
    #1;
    exp_rv = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
    chk("gnt", 64'(o_gnt), 64'(i_req && (exp_q.size() < RD)));
    chk("rvalid", 64'(o_rvalid), 64'(exp_rv));
    if (exp_rv && o_rvalid) begin
      h = exp_q[0];
      chk("rid", 64'(o_rid), 64'(h.id));
      chk("rdata", o_rdata, h.data);
      chk("rerr", 64'(o_rerr), 64'(h.err));
      if (i_rready) void'(exp_q.pop_front());
    end
    accepted = i_req && o_gnt;
    if (accepted) begin
      r = model_accept();
      if (tbl_mode) begin
        r.data = tbl_data;
        r.err = tbl_err;
      end
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic we, input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                         input logic [DW-1:0] wdata, input logic [IW-1:0] aid);
    i_req = 1'b1; i_we = we; i_addr = addr; i_be = be; i_wdata = wdata; i_aid = aid;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                       input logic [DW-1:0] wdata, input logic [IW-1:0] aid);
    bit done;
    done = 1'b0;
    set_req(we, addr, be, wdata, aid);
    for (int t = 0; t < 40 && !done; t++) begin
      step();
      done = accepted;
    end
    chk("issue_granted", 64'(done), 64'(1));
    i_req = 1'b0;
  endtask

  task automatic drain();
    i_req = 1'b0;
    i_rready = 1'b1;
    for (int t = 0; t < 60 && exp_q.size() > 0; t++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    step();
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    be;
    logic [DW-1:0] wdata;
    logic [IW-1:0] aid;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int ng;
    int a;
    logic [DW-1:0] aa, w0_after;

    aa = {DW/8{8'hAA}};
    w0_after = ERR ? 64'h5555555555555555 : aa;
    vt[0]  = '{1'b1, 32'h00,   8'hFF, 64'h5555555555555555, 2'd0, 64'h0, 1'b0};
    vt[1]  = '{1'b1, 32'h10,   8'hFF, 64'h0123456789ABCDEF, 2'd1, 64'h0, 1'b0};
    vt[2]  = '{1'b0, 32'h10,   8'h00, 64'h0,                2'd2, 64'h0123456789ABCDEF, 1'b0};
    vt[3]  = '{1'b1, 32'h10,   8'h0F, 64'hFFFFFFFFFFFFFFFF, 2'd3, 64'h0, 1'b0};
    vt[4]  = '{1'b0, 32'h10,   8'hFF, 64'h0,                2'd0, 64'h01234567FFFFFFFF, 1'b0};
    vt[5]  = '{1'b1, 32'h18,   8'hFF, 64'h0,                2'd1, 64'h0, 1'b0};
    vt[6]  = '{1'b1, 32'h18,   8'h81, 64'hAABBCCDDEEFF0011, 2'd2, 64'h0, 1'b0};
    vt[7]  = '{1'b0, 32'h18,   8'h00, 64'h0,                2'd3, 64'hAA00000000000011, 1'b0};
    vt[8]  = '{1'b0, 32'h17,   8'h00, 64'h0,                2'd0, 64'h01234567FFFFFFFF, 1'b0};
    vt[9]  = '{1'b1, 32'h10,   8'h00, 64'h1111111111111111, 2'd1, 64'h0, 1'b0};
    vt[10] = '{1'b0, 32'h10,   8'h00, 64'h0,                2'd2, 64'h01234567FFFFFFFF, 1'b0};
    vt[11] = '{1'b1, 32'h2000, 8'hFF, aa,                   2'd3, 64'h0, ERR};
    vt[12] = '{1'b0, 32'h0,    8'h00, 64'h0,                2'd0, w0_after, 1'b0};
    vt[13] = '{1'b0, 32'h2000, 8'h00, 64'h0,                2'd1, ERR ? 64'h0 : aa, ERR};

    // reset state
    rstn = 1'b0;
    i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_be = '0; i_wdata = '0; i_aid = '0; i_rready = 1'b0;
    #1;
    chk("reset_gnt", 64'(o_gnt), 64'(0));
    chk("reset_rvalid", 64'(o_rvalid), 64'(0));
    chk("reset_rid", 64'(o_rid), 64'(0));
    chk("reset_rdata", o_rdata, 64'(0));
    chk("reset_rerr", 64'(o_rerr), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // directed table, back-to-back with rready high
    i_rready = 1'b1;
    tbl_mode = 1'b1;
    for (int v = 0; v < NV; v++) begin
      tbl_data = vt[v].exp_data;
      tbl_err = vt[v].exp_err;
      issue(vt[v].we, vt[v].addr, vt[v].be, vt[v].wdata, vt[v].aid);
    end
    tbl_mode = 1'b0;
    drain();

    // give words 0..31 known content
    for (int w = 0; w < 32; w++)
      issue(1'b1, AW'(w * 8), 8'hFF, {$urandom, $urandom}, IW'(w));
    drain();

    // back-pressure: only RD grants with rready low, then one pop reopens the grant
    i_rready = 1'b0;
    ng = 0;
    a = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(1'b0, AW'(a * 8), 8'h00, 64'h0, IW'(a));
      step();
      if (accepted) begin ng++; a++; end
    end
    chk("bp_grant_count", 64'(ng), 64'(RD));
    chk("bp_gnt_low", 64'(o_gnt), 64'(0));
    chk("bp_head_rvalid", 64'(o_rvalid), 64'(1));
    chk("bp_head_rid", 64'(o_rid), 64'(0));
    i_rready = 1'b1;
    step();
    i_rready = 1'b0;
    chk("bp_next_rid", 64'(o_rid), 64'(1));
    chk("bp_gnt_after_pop", 64'(o_gnt), 64'(1));
    step();
    drain();

    // streaming: one grant per cycle across pointer wrap
    i_rready = 1'b1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      set_req(1'b0, AW'($urandom_range(0, 31) * 8), 8'h00, 64'h0, IW'(c % 4));
      step();
      if (accepted) ng++;
    end
    chk("stream_grant_count", 64'(ng), 64'(16));
    drain();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      i_req = ($urandom_range(0, 9) < 7);
      i_we = 1'($urandom_range(0, 1));
      i_addr = AW'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) i_addr = i_addr + 32'h2000;
      i_be = 8'($urandom);
      i_wdata = {$urandom, $urandom};
      i_aid = IW'($urandom);
      i_rready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();

    // reset with responses queued
    i_rready = 1'b0;
    issue(1'b0, 32'h10, 8'h00, 64'h0, 2'd1);
    issue(1'b0, 32'h18, 8'h00, 64'h0, 2'd2);
    issue(1'b0, 32'h20, 8'h00, 64'h0, 2'd3);
    step();
    step();
    chk("prereset_rvalid", 64'(o_rvalid), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("midreset_rvalid", 64'(o_rvalid), 64'(0));
    chk("midreset_rid", 64'(o_rid), 64'(0));
    chk("midreset_rdata", o_rdata, 64'(0));
    chk("midreset_gnt", 64'(o_gnt), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    step();
    #2;
    rstn = 1'b1;
    step();
    step();
    i_rready = 1'b1;
    issue(1'b0, 32'h10, 8'h00, 64'h0, 2'd0);
    issue(1'b0, 32'h18, 8'h00, 64'h0, 2'd1);
    issue(1'b0, 32'h20, 8'h00, 64'h0, 2'd2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
